memory_access: RTL
==================

# memory_access

Memory-access (MA) stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. It consumes the EX/MEM register contents: ALU result, forwarded rs2, byte enables and destination info. It runs the data-memory read/write handshake, stalls the upstream pipeline while an access is outstanding, aligns and sign-extends load data, and drives the MEM/WB register used by writeback and by EX forwarding.

## Interface
Parameters: none.

- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM register holds a real instruction; 0 means bubble.
- ex_load  in  1  instruction is a load.
- ex_store  in  1  instruction is a store.
- ex_funct3  in  3  load width: lb=000, lh=001, lw=010, lbu=100, lhu=101.
- ex_rd  in  5  destination register.
- ex_regfile_we  in  1  instruction writes rd.
- ex_alu_out  in  32  memory byte address for loads/stores; writeback value otherwise.
- ex_rs2  in  32  forwarded store data, unshifted.
- ex_mem_byte_enable  in  4  byte enables already aligned to the address.
- dmem_read  out  1  data read request, registered.
- dmem_write  out  1  data write request, registered.
- dmem_address  out  32  word-aligned address {addr[31:2],2'b00}, registered.
- dmem_wdata  out  32  store data shifted left by 8*addr[1:0], registered.
- dmem_byte_enable  out  4  registered copy of ex_mem_byte_enable.
- dmem_rdata  in  32  read data, valid when dmem_resp=1.
- dmem_resp  in  1  single-cycle completion pulse.
- ma_stall  out  1  combinational; upstream (IF/ID/EX) holds while 1.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_rd  out  5  destination register.
- wb_we  out  1  regfile write enable, already ANDed with wb_valid.
- wb_data  out  32  writeback value; this is also the MA/WB forwarding data.

## Operation
- A memory op is ex_valid & (ex_load | ex_store). If ex_load and ex_store are both 1, treat the op as a load.
- The stage uses a two-state FSM.
- **IDLE state:**
  - With a memory op present: ma_stall=1. On the next edge, latch dmem_address, dmem_wdata and dmem_byte_enable. Set dmem_read=ex_load or dmem_write=ex_store (never both). Go to BUSY.
  - With no memory op present: ma_stall=0.
- **BUSY state:**
  - The request outputs stay stable.
  - ma_stall = !dmem_resp.
  - On the edge where dmem_resp=1, deassert both requests and return to IDLE.
- **MEM/WB register** (wb_*) loads on every edge where ma_stall=0:
  - wb_valid ← ex_valid.
  - wb_rd ← ex_rd.
  - wb_we ← ex_valid & ex_regfile_we.
  - wb_data ← the load result for loads (computed from dmem_rdata in the resp cycle), else ex_alu_out.
- On edges where ma_stall=1, load a bubble into MEM/WB: wb_valid=0, wb_we=0. wb_rd and wb_data keep their old values.
- **Load alignment** uses the byte offset o = ex_alu_out[1:0] (EX/MEM is held, so it is still valid in the resp cycle). Compute s = dmem_rdata >> 8*o, then:
  - lb: sign-extend s[7:0].
  - lbu: zero-extend s[7:0].
  - lh: sign-extend s[15:0].
  - lhu: zero-extend s[15:0].
  - lw and undefined funct3: s.
- A dmem_resp that arrives in IDLE is ignored.

## Timing
- Reset value of every output: 0. The FSM resets to IDLE.
- Reset asserted mid-access drops dmem_read/dmem_write immediately (asynchronously). A dmem_resp arriving after reset release is ignored.
- Non-memory instruction: 1-cycle latency. EX/MEM at cycle n gives MEM/WB at cycle n+1, and ma_stall stays 0.
- Memory op at cycle n:
  - ma_stall=1 in cycle n.
  - Request is visible in cycle n+1.
  - If dmem_resp arrives in cycle n+k (k≥1): ma_stall=0 in cycle n+k, and MEM/WB is valid in cycle n+k+1.
  - Minimum total latency is 2 cycles.
- Back-to-back memory ops: the second op enters IDLE at cycle n+k+1 and issues its request at n+k+2. There is one idle request cycle between consecutive accesses.
- The request outputs never change while in BUSY.

## Test plan
- **Reset:** hold rst=0 with random inputs → all outputs 0. Release rst, apply no ops → ma_stall=0 and wb_valid=0.
- **ALU passthrough:** apply ex_valid=1, rd=5, we=1, alu_out=0x1234 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, and dmem_read=0.
- **lb with sign-extension:**
  - Stimulus: addr=0x103, funct3=000, dmem_rdata=0x80FF_0000, resp after 3 cycles.
  - Required: dmem_read=1 with address 0x100 for 3 cycles, ma_stall=1 until the resp cycle, then wb_data=0xFFFF_FF80.
  - Repeat with lbu → wb_data=0x80.
- **lh/lhu at offset 2:**
  - Stimulus: dmem_rdata=0x8001_1234.
  - Required: lh → 0xFFFF_8001; lhu → 0x0000_8001.
- **sw at offset 0 and sb at offset 1:**
  - sb stimulus: rs2=0xAB, be=0010.
  - Required: dmem_wdata=0x0000_AB00, dmem_write=1, be=0010, and wb_we=0 after resp.
- **Stall bubbles and reset mid-access:**
  - Stimulus: resp delayed 4 cycles.
  - Required: wb_valid=0 in every stall cycle.
  - Then pull rst low while in BUSY → dmem_read drops immediately. A later stray dmem_resp produces no writeback.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access stage of the RV32I pipeline. It issues registered data-memory
// requests, stalls upstream stages until the single-cycle response arrives,
// aligns and extends load data, and drives the MEM/WB register.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regfile_we,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2,
    input  logic [3:0]  ex_mem_byte_enable,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        ma_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_address_q, dmem_address_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_byte_enable_q, dmem_byte_enable_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        mem_op;
    logic [1:0]  byte_off;
    logic [31:0] shifted_rdata;
    logic [31:0] load_data;

    assign mem_op   = ex_valid & (ex_load | ex_store);
    assign byte_off = ex_alu_out[1:0];

    // Load alignment: shift the addressed byte/half down, then extend by width.
    always_comb begin
        shifted_rdata = dmem_rdata >> {byte_off, 3'b000};
        case (ex_funct3)
            3'b000:  load_data = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b100:  load_data = {24'd0, shifted_rdata[7:0]};
            3'b001:  load_data = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b101:  load_data = {16'd0, shifted_rdata[15:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    // Request FSM next-state, request registers and stall.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d            = state_q;
        dmem_read_d        = dmem_read_q;
        dmem_write_d       = dmem_write_q;
        dmem_address_d     = dmem_address_q;
        dmem_wdata_d       = dmem_wdata_q;
        dmem_byte_enable_d = dmem_byte_enable_q;
        ma_stall           = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    ma_stall           = 1'b1;
                    state_d            = BUSY;
                    dmem_read_d        = ex_load;
                    // A load+store encoding is treated as a load only.
                    dmem_write_d       = ex_store & ~ex_load;
                    dmem_address_d     = {ex_alu_out[31:2], 2'b00};
                    dmem_wdata_d       = ex_rs2 << {byte_off, 3'b000};
                    dmem_byte_enable_d = ex_mem_byte_enable;
                end
            end
            BUSY: begin
                ma_stall = ~dmem_resp;
                if (dmem_resp) begin
                    state_d      = IDLE;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Keep every output at 0 while reset is held, including the stall.
        if (!rst) ma_stall = 1'b0;
    end

    // MEM/WB next value: advance when not stalled, otherwise insert a bubble.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (!ma_stall) begin
            wb_valid_d = ex_valid;
            wb_rd_d    = ex_rd;
            wb_we_d    = ex_valid & ex_regfile_we;
            wb_data_d  = (ex_valid & ex_load) ? load_data : ex_alu_out;
        end
    end

    // State, request and MEM/WB registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            dmem_read_q        <= 1'b0;
            dmem_write_q       <= 1'b0;
            dmem_address_q     <= 32'd0;
            dmem_wdata_q       <= 32'd0;
            dmem_byte_enable_q <= 4'd0;
            wb_valid_q         <= 1'b0;
            wb_rd_q            <= 5'd0;
            wb_we_q            <= 1'b0;
            wb_data_q          <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q            <= state_d;
            dmem_read_q        <= dmem_read_d;
            dmem_write_q       <= dmem_write_d;
            dmem_address_q     <= dmem_address_d;
            dmem_wdata_q       <= dmem_wdata_d;
            dmem_byte_enable_q <= dmem_byte_enable_d;
            wb_valid_q         <= wb_valid_d;
            wb_rd_q            <= wb_rd_d;
            wb_we_q            <= wb_we_d;
            wb_data_q          <= wb_data_d;
        end
    end

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = dmem_byte_enable_q;
    assign wb_valid         = wb_valid_q;
    assign wb_rd            = wb_rd_q;
    assign wb_we            = wb_we_q;
    assign wb_data          = wb_data_q;

endmodule
